// File: rtl/argmax_classifier.sv
// Streaming argmax over one frame of NUM_CLASSES signed scores.
// Result is held with a valid/ready handshake until consumed.
module argmax_classifier #(
    parameter int RESOLUTION  = 8,
    parameter int NUM_CLASSES = 10,
    parameter int CLASS_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic signed [RESOLUTION-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [CLASS_W-1:0]    out_class,
    output logic signed [RESOLUTION-1:0] out_score
);

    localparam logic [CLASS_W-1:0] LAST = CLASS_W'(NUM_CLASSES - 1);

    generate
        if ((2 ** CLASS_W) < NUM_CLASSES) begin : g_bad_class_w
            $error("CLASS_W too narrow for NUM_CLASSES");
        end
    endgenerate

    typedef enum logic {
        ACC,
        HOLD
    } state_t;

    state_t                      state;
    logic        [CLASS_W-1:0]   idx;
    logic signed [RESOLUTION-1:0] run_max;
    logic        [CLASS_W-1:0]   run_class;

    // Strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ACC;
            idx       <= '0;
            run_max   <= '0;
            run_class <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (in_valid) begin
                        if (idx == '0) begin
                            run_max   <= in_data;
                            run_class <= '0;
                        end else if (in_data > run_max) begin
                            run_max   <= in_data;
                            run_class <= idx;
                        end
                        if (idx == LAST) begin
                            idx       <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= ACC;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACC;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_class = run_class;
    assign out_score = run_max;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed and randomized checks of argmax_classifier against
// a max-then-first-index reference model.
module tb_argmax_classifier;

    localparam int RES = 8;
    localparam int NC  = 10;
    localparam int CW  = 4;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic signed [RES-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic        [CW-1:0]  out_class;
    logic signed [RES-1:0] out_score;

    int n_cmp = 0;
    int n_err = 0;

    argmax_classifier #(
        .RESOLUTION (RES),
        .NUM_CLASSES(NC),
        .CLASS_W    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_class(out_class),
        .out_score(out_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: find the maximum value, then its first occurrence.
    task automatic ref_argmax(input int s[NC], output int cls, output int mx);
        mx = s[0];
        for (int i = 1; i < NC; i++)
            if (s[i] > mx) mx = s[i];
        cls = -1;
        for (int i = NC - 1; i >= 0; i--)
            if (s[i] == mx) cls = i;
    endtask

    // Push n scores; duty is the percent chance in_valid is high per cycle.
    task automatic send(input int s[NC], input int n, input int duty);
        int  k   = 0;
        int  cyc = 0;
        logic xfer;
        while (k < n && cyc < 2000) begin
            in_valid = ($urandom_range(99) < duty);
            in_data  = in_valid ? RES'(s[k]) : RES'($urandom);
            xfer     = in_valid && in_ready;
            if (xfer && k == NC - 1)
                chk("ov_before_last", out_valid, 0);
            tick();
            cyc++;
            if (xfer) begin
                k++;
                if (k == NC) chk("ov_after_last", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        if (k < n) chk("send_timeout", k, n);
    endtask

    // Check held result, optionally stalling with junk input, then consume.
    task automatic take(input int ecls, input int escore, input int stall);
        chk("out_valid", out_valid, 1);
        chk("out_class", out_class, ecls);
        chk("out_score", out_score, escore);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 8'sd127;
            tick();
            chk("hold_in_ready", in_ready, 0);
            chk("hold_class", out_class, ecls);
            chk("hold_score", out_score, escore);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consumed_ov", out_valid, 0);
        chk("consumed_ir", in_ready, 1);
    endtask

    task automatic chk_reset_state();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_class", out_class, 0);
        chk("rst_score", out_score, 0);
    endtask

    initial begin
        int s[NC];
        int ecls;
        int emx;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_state();

        s = '{5, -3, 12, 7, 0, -128, 11, 12, 1, 2};
        send(s, NC, 100);
        take(2, 12, 0);

        s = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
        send(s, NC, 100);
        take(0, -128, 0);

        s = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
        send(s, NC, 100);
        take(0, 127, 0);

        s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
        send(s, NC, 100);
        take(9, 100, 5);

        s = '{-5, -1, -128, -1, -7, -2, -9, -3, -4, -6};
        send(s, NC, 100);
        take(1, -1, 0);

        s = '{50, 60, 70, 80, 0, 0, 0, 0, 0, 0};
        send(s, 4, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state();
        s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        send(s, NC, 100);
        take(9, 10, 0);

        s = '{-1, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        send(s, NC, 100);
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b0;
        chk_reset_state();
        s = '{9, 9, -9, 20, 20, 1, 1, 1, 1, 1};
        send(s, NC, 100);
        take(3, 20, 0);

        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < NC; i++) begin
                case ($urandom_range(3))
                    0:       s[i] = -128;
                    1:       s[i] = 127;
                    2:       s[i] = int'($urandom_range(6)) - 3;
                    default: s[i] = int'($urandom_range(255)) - 128;
                endcase
            end
            ref_argmax(s, ecls, emx);
            send(s, NC, 50);
            take(ecls, emx, int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter: RESOLUTION, default 8, bit width of each signed neuron score.
REQ-002 Parameter: NUM_CLASSES, default 10, number of scores per classification frame.
REQ-003 Parameter: CLASS_W, default 4, width of the class index; 2^CLASS_W >= NUM_CLASSES SHALL hold.
REQ-004 Port: clk  input  1  the single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  upstream score on in_data is valid.
REQ-007 Port: in_data  input  RESOLUTION  signed two's-complement output-layer neuron score.
REQ-008 Port: in_ready  output  1  block accepts a score this cycle.
REQ-009 Port: out_valid  output  1  classification result is valid and held.
REQ-010 Port: out_ready  input  1  downstream consumes the result.
REQ-011 Port: out_class  output  CLASS_W  index (0..NUM_CLASSES-1) of the maximum score.
REQ-012 Port: out_score  output  RESOLUTION  signed maximum score value.

Function
REQ-013 Scores SHALL arrive serially, one per accepted transfer, in class order 0..NUM_CLASSES-1; transfer accepted when in_valid && in_ready at a rising edge.
REQ-014 Two states SHALL exist: ACC (collecting scores) and HOLD (presenting result).
REQ-015 In ACC: in_ready=1, out_valid=0; in HOLD: in_ready=0, out_valid=1.
REQ-016 An internal index counter (CLASS_W bits) SHALL count accepted scores within the frame, starting at 0.
REQ-017 On an accepted score at index 0: running max := in_data, running class := 0 (unconditional load, prior frame discarded).
REQ-018 On an accepted score at index k>0: if in_data > running max (signed, strict), running max := in_data and running class := k; otherwise unchanged.
REQ-019 Ties SHALL resolve to the lowest index (strict comparison only).
REQ-020 Comparison SHALL be signed at RESOLUTION bits; no widening, no saturation; -128 SHALL compare below every other 8-bit value.
REQ-021 On the accepted score at index NUM_CLASSES-1: counter wraps to 0 and state goes to HOLD next cycle; out_valid rises exactly 1 cycle after that transfer, with the final score already included.
REQ-022 In HOLD, out_class and out_score SHALL remain stable until handshake completes.
REQ-023 In HOLD, out_valid && out_ready at a rising edge SHALL return the state to ACC; in_ready rises the following cycle (no combinational ready path from out_ready to in_ready).
REQ-024 in_valid during HOLD SHALL be ignored (no transfer, counter frozen).
REQ-025 in_valid low in ACC SHALL stall: counter, running max and class unchanged; gaps between scores are allowed at any point.
REQ-026 out_class/out_score in ACC SHALL reflect the running values (don't-care to consumers, since out_valid=0).
REQ-027 Throughput: one frame per NUM_CLASSES+1 cycles minimum when out_ready is held high.

Reset
REQ-028 reset=1 at a rising edge SHALL force state ACC, counter 0, running max 0, running class 0, out_valid 0, in_ready 1 on the next cycle.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial frame or pending result; the next accepted score is treated as index 0.
REQ-030 reset SHALL take priority over any simultaneous in_valid or out_ready handshake.

Verification
REQ-031 Frame [5,-3,12,7,0,-128,11,12,1,2], out_ready=1 -> out_valid 1 cycle after 10th transfer, out_class=2, out_score=12 (tie at index 7 ignored).
REQ-032 All scores -128 -> out_class=0, out_score=-128; all scores 127 -> out_class=0, out_score=127.
REQ-033 Max at last index: [0,..,0,100] -> out_class=9, out_score=100; out_valid rises exactly 1 cycle after the last transfer.
REQ-034 out_ready=0 for 5 cycles in HOLD while in_valid=1 with value 127 -> in_ready stays 0, result held unchanged; next frame unaffected by the ignored inputs.
REQ-035 Reset asserted after 4 transfers, then full frame [1,2,3,4,5,6,7,8,9,10] -> out_class=9, out_score=10 (pre-reset scores have no effect).
REQ-036 Random in_valid gaps (~50% duty) over 100 random frames -> results match a reference argmax (lowest index on ties).
